game_event_mailbox: RTL

Parametrised, buffered event channel that carries game-side events (score increments, block type, rotate requests, game state) into the processor domain. It replaces direct wiring of game signals into fixed register-file entries. Up to 16 independent sources arbitrate round-robin into a first-word-fall-through FIFO, and the processor drains that FIFO one 32-bit word at a time. It sits between the game logic and the processor's memory-mapped I/O path in the processor top level.

---
 rtl/game_event_mailbox.sv | 102 ++++++++++
 1 files changed

// File: rtl/game_event_mailbox.sv
// Round-robin event mailbox: CHANNELS sources feed a FWFT FIFO drained by the CPU.
// Define GAME_EVT_TIMESTAMP_EN to stamp each word with a 16-bit cycle counter.
module game_event_mailbox #(
   parameter int CHANNELS  = 4,
   parameter int PAYLOAD_W = 8,
   parameter int DEPTH     = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           evt_valid,
   input  logic [CHANNELS*PAYLOAD_W-1:0] evt_payload,
   output logic [CHANNELS-1:0]           evt_ready,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [31:0]                   rd_data,
   output logic [8:0]                    count,
   output logic [7:0]                    stall_cnt,
   input  logic                          clear_stall
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]         mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [3:0]          last_grant;
   logic [15:0]         stamp;
   logic                found;
   logic [3:0]          win;
   logic [11:0]         win_payload;
   logic [CHANNELS-1:0] win_onehot;
   logic                can_accept;
   logic                push;
   logic                pop;
   int                  best_d;
   int                  d;

   // Pick the valid channel closest after last_grant, wrapping modulo CHANNELS.
   always_comb begin
      best_d      = CHANNELS;
      d           = 0;
      win         = last_grant;
      win_payload = '0;
      win_onehot  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         d = i - int'(last_grant) - 1;
         if (d < 0) d = d + CHANNELS;
         if (evt_valid[i] && d < best_d) begin
            best_d        = d;
            win           = 4'(i);
            win_payload   = 12'(evt_payload[i*PAYLOAD_W +: PAYLOAD_W]);
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
         end
      end
      found = (best_d < CHANNELS);
   end

   always_comb begin
      can_accept = (count < 9'(DEPTH)) || (rd_en && count != 9'd0);
      push       = reset && found && can_accept;
      pop        = reset && rd_en && count != 9'd0;
      evt_ready  = push ? win_onehot : '0;
      rd_valid   = (count != 9'd0);
      rd_data    = rd_valid ? mem[rd_ptr] : 32'd0;
   end

`ifdef GAME_EVT_TIMESTAMP_EN
   always_ff @(posedge clock) begin
      if (!reset) stamp <= 16'd0;
      else        stamp <= stamp + 16'd1;
   end
`else
   assign stamp = 16'd0;
`endif

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {stamp, win, win_payload};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= 9'd0;
         last_grant <= 4'(CHANNELS - 1);
         stall_cnt  <= 8'd0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_grant <= win;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + 9'(push) - 9'(pop);
         if (clear_stall)
            stall_cnt <= 8'd0;
         else if (|evt_valid && !push && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
      end
   end

endmodule
